sram_ctrl: RTL and testbench
============================

# sram_ctrl

Data-memory responder for the Cortex-M0 core. It answers the core's load/store requests (`ld_mem`, `mem_wr`, `addr_mem`, `din_mem`) with read data on `dout_mem` and a `busy_sram` stall signal. Storage is an internal word-organised array behind a small wait-state state machine. It sits beside the core at top level, in the same position as the flash controllers.

## Interface
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, default 1: extra wait states per access, range 0..15.
- `BASE_ADDR`, default 32'h2000_0000: byte address of word 0, aligned to 4·2^DEPTH_LOG2.

Ports:
- `clk` in 1: single clock; all logic updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ld_mem` in 1: access request strobe from the core.
- `mem_wr` in 1: 1 = store, 0 = load; sampled with `ld_mem`.
- `addr_mem` in 32: byte address; bits [1:0] are ignored.
- `din_mem` in 32: store data; sampled with `ld_mem`.
- `dout_mem` out 32: load data; registered and held until the next load completes.
- `busy_sram` out 1: registered; high while an access is in flight.
- `err` out 1: sticky out-of-range flag, registered.

## Operation
- States:
  - IDLE: `busy_sram`=0.
  - WAIT: counter > 0.
  - ACCESS: final cycle.
- Acceptance: on a rising edge with state IDLE and `ld_mem`=1, the block latches `mem_wr`, `din_mem` and word index `addr_mem[DEPTH_LOG2+1:2]`, and computes the range check.
- Transition out of IDLE: goes to WAIT with counter=WAIT_CYCLES, or directly to ACCESS when WAIT_CYCLES=0.
- WAIT: decrements the counter each cycle; moves to ACCESS when the counter reaches 1.
- ACCESS: on its closing edge performs the array access, then returns to IDLE.
  - Load: `dout_mem` ← mem[idx].
  - Store: mem[idx] ← latched data; `dout_mem` is unchanged.
- `ld_mem` while not IDLE is ignored. Requests are not queued; the core must re-present the request after `busy_sram` falls.
- Out-of-range address (addr − BASE_ADDR ≥ 4·2^DEPTH_LOG2): see Configuration.
- The array is not cleared by reset.

## Timing
- Reset values: `busy_sram`=0, `dout_mem`=32'h0, `err`=0, state IDLE, counter 0.
- Access accepted at edge k:
  - `busy_sram`=1 from edge k until edge k+1+WAIT_CYCLES.
  - `busy_sram`=0 and load data valid after edge k+1+WAIT_CYCLES, so busy is high for WAIT_CYCLES+1 cycles.
- Back-to-back: a new request may be accepted on the same edge at which `busy_sram` is observed low, i.e. edge k+2+WAIT_CYCLES at the earliest. Throughput is one access per WAIT_CYCLES+2 cycles.
- Store-then-load to the same word: the load returns the stored data, because the store commits before the load is accepted.
- Reset mid-access:
  - State returns to IDLE on the reset edge.
  - A pending store is dropped, unless its ACCESS edge coincides with the reset edge; in that case reset wins and the store is also dropped.
  - `dout_mem` goes to 0.
- `ld_mem` high together with `rst`: reset wins and the request is not accepted.

## Configuration
- `SRAM_ADDR_CHECK_EN` defined:
  - An out-of-range access still takes full latency.
  - Load returns 32'h0.
  - Store is discarded.
  - `err` sets to 1 on the ACCESS edge and stays set until `rst`.
- `SRAM_ADDR_CHECK_EN` undefined:
  - No range check; the word index wraps modulo 2^DEPTH_LOG2, so upper address bits alias.
  - `err` is tied to 0.

## Test plan
- Reset: hold `rst`=1 for 2 cycles → `busy_sram`=0, `dout_mem`=0, `err`=0.
- Store then load, WAIT_CYCLES=1:
  - Store 32'hDEADBEEF to 32'h2000_0010 → `busy_sram` high for exactly 2 cycles.
  - Load from the same address → `dout_mem`=32'hDEADBEEF on the edge busy falls.
- Ignored request: assert `ld_mem` store to 32'h2000_0020 with 32'h1 while busy, then release `ld_mem` → a later load of 32'h2000_0020 returns the prior contents, not 32'h1.
- Out-of-range, `SRAM_ADDR_CHECK_EN` defined: load from 32'h3000_0000 → `dout_mem`=0 and `err`=1. Without the macro, with DEPTH_LOG2=10, 32'h2000_1010 aliases 32'h2000_0010 and returns 32'hDEADBEEF.
- Reset mid-store: store 32'h55 to 32'h2000_0004 with WAIT_CYCLES=3 and assert `rst` in the second busy cycle → a subsequent load returns the old value and `busy_sram` is 0 the cycle after reset.
- WAIT_CYCLES=0 back-to-back: 4 loads issued as soon as busy falls → each busy pulse lasts 1 cycle and the period is 2 cycles.

Source files
------------

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - word-organised data SRAM responder with wait states (optional SRAM_ADDR_CHECK_EN range check)
module sram_ctrl #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_mem,
    input  logic        mem_wr,
    input  logic [31:0] addr_mem,
    input  logic [31:0] din_mem,
    output logic [31:0] dout_mem,
    output logic        busy_sram,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic                    accept;
    logic                    do_access;
    logic                    busy_nxt;
    logic                    oor_in;

    logic                    wr_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             data_q;
    logic                    oor_q;

    logic [31:0]             dout_q;
    logic                    busy_q;
    logic                    err_q;

    logic [31:0]             mem [0:(1<<DEPTH_LOG2)-1];

`ifdef SRAM_ADDR_CHECK_EN
    // Offset from the window base; any bit above the array span means out of range.
    logic [31:0] offset;
    logic        unused_addr;
    assign offset      = addr_mem - BASE_ADDR;
    assign oor_in      = |offset[31:DEPTH_LOG2+2];
    assign unused_addr = ^addr_mem[1:0];
`else
    // No range check: upper address bits simply alias onto the array.
    logic        unused_addr;
    assign oor_in      = 1'b0;
    assign unused_addr = ^{addr_mem[31:DEPTH_LOG2+2], addr_mem[1:0]};
`endif

    // State register plus registered outputs; reset wins over any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            busy_q <= 1'b0;
            dout_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= busy_nxt;
            if (do_access && !wr_q) begin
                dout_q <= oor_q ? 32'h0 : mem[idx_q];
            end
            if (do_access && oor_q) begin
                err_q <= 1'b1;
            end
        end
    end

    // Request capture on acceptance; held stable for the rest of the access.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            wr_q   <= mem_wr;
            idx_q  <= addr_mem[DEPTH_LOG2+1:2];
            data_q <= din_mem;
            oor_q  <= oor_in;
        end
    end

    // Array write on the ACCESS closing edge; a coincident reset drops the store.
    always_ff @(posedge clk) begin
        if (!rst && do_access && wr_q && !oor_q) begin
            mem[idx_q] <= data_q;
        end
    end

    // Next-state: IDLE -> WAIT (counting down) or straight to ACCESS -> IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (ld_mem) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACCESS;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_ACCESS;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACCESS: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output decode: busy follows the upcoming state so it is registered yet cycle-exact.
    always_comb begin
        accept    = (state == S_IDLE) && ld_mem;
        do_access = (state == S_ACCESS);
        busy_nxt  = (state_nxt != S_IDLE);
    end

    assign dout_mem  = dout_q;
    assign busy_sram = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl at three wait-state settings
module tb_sram_ctrl;

    localparam int WC0 = 1;
    localparam int WC1 = 3;
    localparam int WC2 = 0;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int WORDS = 1024;

    logic        clk;
    logic        rst    [3];
    logic        ld     [3];
    logic        wr     [3];
    logic [31:0] addr   [3];
    logic [31:0] din    [3];
    logic [31:0] dout   [3];
    logic        busy   [3];
    logic        err    [3];

    int tests;
    int fails;
    int cyc;
    int wc       [3];
    int last_acc [3];

    logic [31:0] mdl    [3][WORDS];
    bit          vld    [3][WORDS];
    logic [31:0] dexp   [3];
    bit          dknown [3];
    bit          errm   [3];

    sram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC0), .BASE_ADDR(BASE)) u_w1 (
        .clk(clk), .rst(rst[0]), .ld_mem(ld[0]), .mem_wr(wr[0]), .addr_mem(addr[0]),
        .din_mem(din[0]), .dout_mem(dout[0]), .busy_sram(busy[0]), .err(err[0]));
    sram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC1), .BASE_ADDR(BASE)) u_w3 (
        .clk(clk), .rst(rst[1]), .ld_mem(ld[1]), .mem_wr(wr[1]), .addr_mem(addr[1]),
        .din_mem(din[1]), .dout_mem(dout[1]), .busy_sram(busy[1]), .err(err[1]));
    sram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(WC2), .BASE_ADDR(BASE)) u_w0 (
        .clk(clk), .rst(rst[2]), .ld_mem(ld[2]), .mem_wr(wr[2]), .addr_mem(addr[2]),
        .din_mem(din[2]), .dout_mem(dout[2]), .busy_sram(busy[2]), .err(err[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int i);
        @(negedge clk);
        rst[i] = 1'b1;
        ld[i]  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        dexp[i] = 32'h0; dknown[i] = 1'b1; errm[i] = 1'b0;
        check($sformatf("reset_busy%0d", i), {31'b0, busy[i]}, 32'h0);
        check($sformatf("reset_dout%0d", i), dout[i], 32'h0);
        check($sformatf("reset_err%0d", i), {31'b0, err[i]}, 32'h0);
        rst[i] = 1'b0;
    endtask

    // One access presented at the next edge; optionally re-strobes a store while busy.
    task automatic access(input int i, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit inject);
        int n;
        int idx;
        bit oor;
        @(negedge clk);
        ld[i] = 1'b1; wr[i] = w; addr[i] = a; din[i] = d;
        @(posedge clk);
        last_acc[i] = cyc;
        #1;
        ld[i] = 1'b0;
        if (inject) begin
            ld[i] = 1'b1; wr[i] = 1'b1; addr[i] = BASE + 32'h20; din[i] = 32'h1;
        end
        n = 0;
        while (busy[i] === 1'b1 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            if (inject && n == 1) ld[i] = 1'b0;
        end
        check($sformatf("busy_len%0d", i), n, wc[i] + 1);
`ifdef SRAM_ADDR_CHECK_EN
        oor = (a - BASE) >= 32'(4 * WORDS);
`else
        oor = 1'b0;
`endif
        idx = int'((a >> 2) % WORDS);
        if (oor) errm[i] = 1'b1;
        if (w) begin
            if (dknown[i]) check($sformatf("store_dout_held%0d", i), dout[i], dexp[i]);
            if (!oor) begin
                mdl[i][idx] = d;
                vld[i][idx] = 1'b1;
            end
        end else begin
            if (oor) begin
                dexp[i] = 32'h0; dknown[i] = 1'b1;
            end else begin
                dexp[i] = mdl[i][idx]; dknown[i] = vld[i][idx];
            end
            if (dknown[i]) check($sformatf("load_data%0d@%h", i, a), dout[i], dexp[i]);
        end
        check($sformatf("err%0d", i), {31'b0, err[i]}, {31'b0, errm[i]});
    endtask

    // Store interrupted by reset sampled rst_edge edges after acceptance.
    task automatic store_with_reset(input int i, input logic [31:0] a, input logic [31:0] d,
                                    input int rst_edge);
        @(negedge clk);
        ld[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; din[i] = d;
        @(posedge clk);
        #1;
        ld[i] = 1'b0;
        repeat (rst_edge - 1) @(posedge clk);
        #1;
        rst[i] = 1'b1;
        @(posedge clk);
        #1;
        dexp[i] = 32'h0; dknown[i] = 1'b1; errm[i] = 1'b0;
        check($sformatf("midrst_busy_e%0d", rst_edge), {31'b0, busy[i]}, 32'h0);
        check($sformatf("midrst_dout_e%0d", rst_edge), dout[i], 32'h0);
        rst[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        tests = 0; fails = 0; cyc = 0;
        wc[0] = WC0; wc[1] = WC1; wc[2] = WC2;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; ld[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; din[i] = '0;
            dexp[i] = 32'h0; dknown[i] = 1'b1; errm[i] = 1'b0; last_acc[i] = 0;
            for (int j = 0; j < WORDS; j++) begin
                vld[i][j] = 1'b0; mdl[i][j] = 32'h0;
            end
        end

        for (int i = 0; i < 3; i++) do_reset(i);

        // WAIT_CYCLES=1: store/load, ignored request while busy, aliasing / range check
        access(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
        access(0, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
        access(0, 1'b1, BASE + 32'h20, 32'hCAFE_0020, 1'b0);
        access(0, 1'b0, BASE + 32'h10, 32'h0, 1'b1);
        access(0, 1'b0, BASE + 32'h20, 32'h0, 1'b0);
`ifdef SRAM_ADDR_CHECK_EN
        access(0, 1'b0, 32'h3000_0000, 32'h0, 1'b0);
        access(0, 1'b1, BASE + 32'h1010, 32'h1234_5678, 1'b0);
        access(0, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
`else
        access(0, 1'b0, BASE + 32'h1010, 32'h0, 1'b0);
`endif

        // Request together with reset is dropped
        @(negedge clk);
        rst[0] = 1'b1; ld[0] = 1'b1; wr[0] = 1'b0; addr[0] = BASE + 32'h10;
        @(posedge clk);
        #1;
        rst[0] = 1'b0; ld[0] = 1'b0;
        dexp[0] = 32'h0; dknown[0] = 1'b1; errm[0] = 1'b0;
        check("ld_with_rst_busy", {31'b0, busy[0]}, 32'h0);
        @(posedge clk);
        #1;
        check("ld_with_rst_busy_next", {31'b0, busy[0]}, 32'h0);
        access(0, 1'b0, BASE + 32'h10, 32'h0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15));
            access(0, 1'($urandom_range(0, 1)), a, $urandom(), 1'b0);
        end

        // WAIT_CYCLES=3: reset in the second busy cycle and on the ACCESS edge
        access(1, 1'b1, BASE + 32'h4, 32'hA5A5_0004, 1'b0);
        store_with_reset(1, BASE + 32'h4, 32'h55, 2);
        access(1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
        store_with_reset(1, BASE + 32'h4, 32'h66, 4);
        access(1, 1'b0, BASE + 32'h4, 32'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            a = BASE + 32'(4 * $urandom_range(0, 7));
            access(1, 1'($urandom_range(0, 1)), a, $urandom(), 1'b0);
        end

        // WAIT_CYCLES=0: back-to-back loads at the maximum rate
        for (int k = 0; k < 4; k++) access(2, 1'b1, BASE + 32'(4 * k), $urandom(), 1'b0);
        for (int k = 0; k < 4; k++) begin
            int prev;
            prev = last_acc[2];
            access(2, 1'b0, BASE + 32'(4 * k), 32'h0, 1'b0);
            check($sformatf("b2b_period%0d", k), last_acc[2] - prev, 32'd2);
        end
        for (int k = 0; k < 16; k++) begin
            a = BASE + 32'(4 * $urandom_range(0, 7));
            access(2, 1'($urandom_range(0, 1)), a, $urandom(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
